// File: rtl/id_lifecycle_tracker.sv
// id_lifecycle_tracker: circular instruction-ID pool with a per-ID lifecycle table (FREE/PRE/INFLIGHT).
// Define ID_TRACKER_OCCUPANCY_EN to add the inflight_count / inflight_hwm occupancy outputs.
module id_lifecycle_tracker #(
    parameter  int unsigned MAX_IDS            = 8,
    parameter  int unsigned NUM_COMPLETE_PORTS = 3,
    localparam int unsigned IDW                = $clog2(MAX_IDS),
    localparam int unsigned RW                 = $clog2(NUM_COMPLETE_PORTS + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              gc_init_clear,
    input  logic                              gc_fetch_flush,
    output logic [IDW-1:0]                    pc_id,
    output logic                              pc_id_available,
    input  logic                              pc_id_assigned,
    output logic [IDW-1:0]                    fetch_id,
    input  logic                              fetch_complete,
    output logic [IDW-1:0]                    decode_id,
    output logic                              decode_valid,
    input  logic                              decode_advance,
    input  logic                              issue_valid,
    input  logic [IDW-1:0]                    issue_id,
    input  logic                              instruction_issued,
    input  logic [NUM_COMPLETE_PORTS-1:0]     complete_valid,
    input  logic [NUM_COMPLETE_PORTS*IDW-1:0] complete_id,
    output logic [RW-1:0]                     retire_inc,
`ifdef ID_TRACKER_OCCUPANCY_EN
    output logic [IDW:0]                      inflight_count,
    output logic [IDW:0]                      inflight_hwm,
`endif
    output logic                              clearing,
    output logic                              protocol_error
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] E_FREE     = 2'd0;
    localparam logic [1:0] E_PRE      = 2'd1;
    localparam logic [1:0] E_INFLIGHT = 2'd2;

    state_t         state_q, state_d;
    logic [IDW-1:0] clear_idx_q, clear_idx_d;
    logic [IDW-1:0] pc_id_d, fetch_id_d, decode_id_d;
    logic [IDW:0]   fetched_q, fetched_d;
    logic [IDW-1:0] flush_ptr_q, flush_ptr_d;
    logic [IDW:0]   flush_left_q, flush_left_d;
    logic [1:0]     table_q [MAX_IDS];
    logic [1:0]     table_d [MAX_IDS];
    logic [IDW-1:0] cids    [NUM_COMPLETE_PORTS];
    logic [RW-1:0]  comp_cnt;
    logic           err_d;
    logic           active, run, adv_ok, alloc_ok;
    logic [IDW-1:0] dec_new;

    for (genvar g = 0; g < NUM_COMPLETE_PORTS; g++) begin : g_unpack
        assign cids[g] = complete_id[g*IDW +: IDW];
    end

    // Next-state, pointer and table-write logic; later writes carry higher priority
    always_comb begin
        state_d      = state_q;
        clear_idx_d  = clear_idx_q;
        pc_id_d      = pc_id;
        fetch_id_d   = fetch_id;
        decode_id_d  = decode_id;
        fetched_d    = fetched_q;
        flush_ptr_d  = flush_ptr_q;
        flush_left_d = flush_left_q;
        table_d      = table_q;
        comp_cnt     = '0;
        err_d        = 1'b0;
        active       = (state_q != ST_CLEAR);
        run          = (state_q == ST_RUN);
        adv_ok       = run & decode_advance & decode_valid;
        alloc_ok     = run & pc_id_assigned & pc_id_available & ~gc_fetch_flush;
        dec_new      = decode_id + IDW'(adv_ok);

        if (run & pc_id_assigned & ~pc_id_available) err_d = 1'b1;
        if (run & decode_advance & ~decode_valid)    err_d = 1'b1;

        case (state_q)
            ST_CLEAR: begin
                table_d[clear_idx_q] = E_FREE;
                clear_idx_d          = clear_idx_q + IDW'(1);
                if (clear_idx_q == IDW'(MAX_IDS - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (alloc_ok) begin
                    table_d[pc_id] = E_PRE;
                    pc_id_d        = pc_id + IDW'(1);
                end
                if (fetch_complete) fetch_id_d = fetch_id + IDW'(1);
                decode_id_d = dec_new;
                fetched_d   = fetched_q + (IDW+1)'(fetch_complete) - (IDW+1)'(adv_ok);
                if (gc_fetch_flush) begin
                    pc_id_d      = dec_new;
                    fetch_id_d   = dec_new;
                    fetched_d    = '0;
                    flush_ptr_d  = dec_new;
                    flush_left_d = {1'b0, IDW'(pc_id - dec_new)};
                    if (issue_valid & ~instruction_issued) table_d[issue_id] = E_FREE;
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_left_q != '0) begin
                    if (table_q[flush_ptr_q] == E_PRE) table_d[flush_ptr_q] = E_FREE;
                    flush_ptr_d  = flush_ptr_q + IDW'(1);
                    flush_left_d = flush_left_q - (IDW+1)'(1);
                end
                if (flush_left_q <= (IDW+1)'(1)) state_d = ST_RUN;
            end
            default: state_d = ST_CLEAR;
        endcase

        if (active && instruction_issued) begin
            table_d[issue_id] = E_INFLIGHT;
            if (alloc_ok && (issue_id == pc_id)) err_d = 1'b1;
        end

        // Completion ports free their IDs and flag illegal or duplicate frees
        if (active) begin
            for (int unsigned p = 0; p < NUM_COMPLETE_PORTS; p++) begin
                if (complete_valid[p]) begin
                    table_d[cids[p]] = E_FREE;
                    comp_cnt         = comp_cnt + RW'(1);
                    if (table_q[cids[p]] != E_INFLIGHT) err_d = 1'b1;
                    if (instruction_issued && (issue_id == cids[p])) err_d = 1'b1;
                    for (int unsigned q = 0; q < p; q++) begin
                        if (complete_valid[q] && (cids[q] == cids[p])) err_d = 1'b1;
                    end
                end
            end
        end

        if (gc_init_clear) begin
            state_d      = ST_CLEAR;
            clear_idx_d  = '0;
            pc_id_d      = '0;
            fetch_id_d   = '0;
            decode_id_d  = '0;
            fetched_d    = '0;
            flush_ptr_d  = '0;
            flush_left_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        table_q <= table_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_CLEAR;
            clear_idx_q     <= '0;
            pc_id           <= '0;
            fetch_id        <= '0;
            decode_id       <= '0;
            fetched_q       <= '0;
            flush_ptr_q     <= '0;
            flush_left_q    <= '0;
            pc_id_available <= 1'b0;
            decode_valid    <= 1'b0;
            retire_inc      <= '0;
            clearing        <= 1'b1;
            protocol_error  <= 1'b0;
        end else begin
            state_q         <= state_d;
            clear_idx_q     <= clear_idx_d;
            pc_id           <= pc_id_d;
            fetch_id        <= fetch_id_d;
            decode_id       <= decode_id_d;
            fetched_q       <= fetched_d;
            flush_ptr_q     <= flush_ptr_d;
            flush_left_q    <= flush_left_d;
            pc_id_available <= (table_d[pc_id_d] == E_FREE) && (state_d == ST_RUN);
            decode_valid    <= (fetched_d != '0);
            retire_inc      <= comp_cnt;
            clearing        <= (state_d == ST_CLEAR);
            protocol_error  <= protocol_error | err_d;
        end
    end

`ifdef ID_TRACKER_OCCUPANCY_EN
    logic [IDW:0] inflight_d;

    // Occupancy: issues minus completions, zeroed by any clear sweep
    always_comb begin
        inflight_d = inflight_count;
        if ((state_q == ST_CLEAR) || gc_init_clear) begin
            inflight_d = '0;
        end else begin
            inflight_d = inflight_count + (IDW+1)'(instruction_issued) - (IDW+1)'(comp_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_count <= '0;
            inflight_hwm   <= '0;
        end else begin
            inflight_count <= inflight_d;
            if (inflight_d > inflight_hwm) inflight_hwm <= inflight_d;
        end
    end
`endif

endmodule

// File: tb/tb_id_lifecycle_tracker.sv
// Directed self-checking bench for id_lifecycle_tracker (MAX_IDS=8, three completion ports).
module tb_id_lifecycle_tracker;

    localparam int unsigned IDW = 3;
    localparam int unsigned NP  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            gc_init_clear, gc_fetch_flush;
    logic [IDW-1:0]  pc_id, fetch_id, decode_id, issue_id;
    logic            pc_id_available, pc_id_assigned, fetch_complete;
    logic            decode_valid, decode_advance, issue_valid, instruction_issued;
    logic [NP-1:0]   complete_valid;
    logic [NP*IDW-1:0] complete_id;
    logic [1:0]      retire_inc;
    logic            clearing, protocol_error;
`ifdef ID_TRACKER_OCCUPANCY_EN
    logic [IDW:0]    inflight_count, inflight_hwm;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n;
    int ok;

    id_lifecycle_tracker #(.MAX_IDS(8), .NUM_COMPLETE_PORTS(NP)) dut (
        .clk(clk), .rst(rst),
        .gc_init_clear(gc_init_clear), .gc_fetch_flush(gc_fetch_flush),
        .pc_id(pc_id), .pc_id_available(pc_id_available), .pc_id_assigned(pc_id_assigned),
        .fetch_id(fetch_id), .fetch_complete(fetch_complete),
        .decode_id(decode_id), .decode_valid(decode_valid), .decode_advance(decode_advance),
        .issue_valid(issue_valid), .issue_id(issue_id), .instruction_issued(instruction_issued),
        .complete_valid(complete_valid), .complete_id(complete_id),
        .retire_inc(retire_inc),
`ifdef ID_TRACKER_OCCUPANCY_EN
        .inflight_count(inflight_count), .inflight_hwm(inflight_hwm),
`endif
        .clearing(clearing), .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear(output int cycles);
        cycles = 0;
        while (clearing && cycles < 20) begin
            cycles++;
            step();
        end
    endtask

    task automatic issue(input int id);
        issue_valid = 1'b1; instruction_issued = 1'b1; issue_id = IDW'(id);
        step();
        issue_valid = 1'b0; instruction_issued = 1'b0;
    endtask

    task automatic set_comp(input int p, input int id);
        complete_valid[p] = 1'b1;
        complete_id[p*IDW +: IDW] = IDW'(id);
    endtask

    task automatic assign_n(input int cnt, output int avail_seen);
        avail_seen = 0;
        for (int i = 0; i < cnt; i++) begin
            if (pc_id_available) avail_seen++;
            pc_id_assigned = 1'b1;
            step();
        end
        pc_id_assigned = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        {gc_init_clear, gc_fetch_flush, pc_id_assigned, fetch_complete} = '0;
        {decode_advance, issue_valid, instruction_issued} = '0;
        issue_id = '0; complete_valid = '0; complete_id = '0;
        #12;
        check("rst_clearing", int'(clearing), 1);
        check("rst_pc_id", int'(pc_id), 0);
        check("rst_avail", int'(pc_id_available), 0);
        check("rst_decode_valid", int'(decode_valid), 0);
        check("rst_retire", int'(retire_inc), 0);
        check("rst_perr", int'(protocol_error), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Power-up sweep
        wait_clear(n);
        check("sweep_len", n, 8);
        check("sweep_avail", int'(pc_id_available), 1);
        check("sweep_pc_id", int'(pc_id), 0);

        // Fill the pool, then free ID 0 through port 2
        assign_n(8, ok);
        check("fill_avail_seen", ok, 8);
        check("fill_avail_after", int'(pc_id_available), 0);
        check("fill_pc_wrap", int'(pc_id), 0);
        issue(0);
        set_comp(2, 0);
        step();
        complete_valid = '0;
        check("free0_avail", int'(pc_id_available), 1);
        check("free0_retire", int'(retire_inc), 1);
        check("free0_perr", int'(protocol_error), 0);

        // Global clear sweep frees the leftover PRE entries
        gc_init_clear = 1'b1; step(); gc_init_clear = 1'b0;
        wait_clear(n);
        check("gc_sweep_len", n, 8);

        // Fetch flush: 5 allocated, 3 fetched, 1 decoded
        assign_n(5, ok);
        check("pre_flush_pc", int'(pc_id), 5);
        fetch_complete = 1'b1; step(); step(); step(); fetch_complete = 1'b0;
        check("fetch_id", int'(fetch_id), 3);
        check("fetch_decode_valid", int'(decode_valid), 1);
        decode_advance = 1'b1; step(); decode_advance = 1'b0;
        check("decode_id", int'(decode_id), 1);
        gc_fetch_flush = 1'b1; step(); gc_fetch_flush = 1'b0;
        check("flush_pc", int'(pc_id), 1);
        check("flush_fetch", int'(fetch_id), 1);
        check("flush_decode_valid", int'(decode_valid), 0);
        n = 0;
        while (!pc_id_available && n < 20) begin
            n++;
            step();
        end
        check("flush_len", n, 4);
        assign_n(7, ok);
        check("post_flush_avail_seen", ok, 7);
        check("post_flush_pc", int'(pc_id), 0);
        check("post_flush_avail", int'(pc_id_available), 0);

        // Three simultaneous legal completions
        issue(0); issue(1); issue(2);
        set_comp(0, 0); set_comp(1, 1); set_comp(2, 2);
        step();
        complete_valid = '0;
        check("triple_retire", int'(retire_inc), 3);
        check("triple_perr", int'(protocol_error), 0);
        check("triple_avail", int'(pc_id_available), 1);
        step();
        check("retire_idle", int'(retire_inc), 0);
`ifdef ID_TRACKER_OCCUPANCY_EN
        check("occ_after_triple", int'(inflight_count), 0);
        check("hwm_after_triple", int'(inflight_hwm), 3);
`endif

        // Clear sweep with five IDs in flight
        for (int i = 3; i < 8; i++) issue(i);
`ifdef ID_TRACKER_OCCUPANCY_EN
        check("occ_five", int'(inflight_count), 5);
`endif
        gc_init_clear = 1'b1; step(); gc_init_clear = 1'b0;
        check("gc2_clearing", int'(clearing), 1);
        wait_clear(n);
        check("gc2_sweep_len", n, 8);
        check("gc2_pc", int'(pc_id), 0);
        check("gc2_fetch", int'(fetch_id), 0);
        check("gc2_decode", int'(decode_id), 0);
        check("gc2_avail", int'(pc_id_available), 1);
`ifdef ID_TRACKER_OCCUPANCY_EN
        check("gc2_occ", int'(inflight_count), 0);
        check("gc2_hwm", int'(inflight_hwm), 5);
`endif
        assign_n(8, ok);
        check("gc2_all_free", ok, 8);
        check("gc2_perr", int'(protocol_error), 0);

        // Duplicate completion on two ports
        issue(3);
        set_comp(0, 3); set_comp(1, 3);
        step();
        complete_valid = '0;
        check("dup_perr", int'(protocol_error), 1);
        check("dup_retire", int'(retire_inc), 2);
        step(); step(); step();
        check("dup_sticky", int'(protocol_error), 1);

        // Reset, then complete a FREE ID
        rst = 1'b0;
        #1;
        check("rst2_perr", int'(protocol_error), 0);
        check("rst2_clearing", int'(clearing), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        wait_clear(n);
        check("rst2_sweep_len", n, 8);
`ifdef ID_TRACKER_OCCUPANCY_EN
        check("rst2_hwm", int'(inflight_hwm), 0);
`endif
        set_comp(0, 5);
        step();
        complete_valid = '0;
        check("free_comp_perr", int'(protocol_error), 1);
        step();
        check("free_comp_sticky", int'(protocol_error), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
